// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl_pkg
//  Description : Shared state encoding and default widths for the data-memory
//                access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_ctrl_pkg;

  localparam int c_ADDR_W      = 32;
  localparam int c_DATA_W      = 32;
  localparam int c_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True while a memory request is outstanding.
  function automatic logic is_busy(input state_e s);
    return (s == ST_RD) || (s == ST_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl_if
//  Description : Pipeline-side request strobes, memory req/ack handshake and
//                status outputs of the data-memory access controller.
//                master = controller view, slave = pipeline/memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_ctrl_if
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
);

  // Pipeline request side (strobes are active-low)
  logic              DmemREB;
  logic              DmemWEB;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Memory handshake
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Status back to the pipeline
  logic [DATA_W-1:0] rdata_out;
  logic              rdata_valid;
  logic              stall;
  logic              err;

  modport master (
    input  DmemREB, DmemWEB, req_addr, req_wdata, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output rdata_out, rdata_valid, stall, err
  );

  modport slave (
    output DmemREB, DmemWEB, req_addr, req_wdata, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  rdata_out, rdata_valid, stall, err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_timeout_cnt
//  Description : Wait-cycle counter for an outstanding memory request.
//                Clears while idle, counts each un-acked wait cycle, flags
//                expiry on the last permitted wait cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;

  // Next count: clear has priority, saturate at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != c_LAST)) begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : Sequences EX/MEM data-memory loads/stores over a req/ack
//                handshake and stalls the pipeline until each access
//                completes. Optional request timeout enabled by the macro
//                DMEM_TIMEOUT_EN (adds the TIMEOUT_CYC parameter).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = c_ADDR_W,
`ifdef DMEM_TIMEOUT_EN
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC,
`endif
  parameter int DATA_W      = c_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  dmem_access_ctrl_if.master  dmem
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_out_q, rdata_out_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;

  logic w_rd_req;
  logic w_wr_req;
  logic w_illegal;
  logic w_busy;
  logic w_timeout;
  logic w_stall;

  assign w_rd_req  = !dmem.DmemREB &&  dmem.DmemWEB;
  assign w_wr_req  =  dmem.DmemREB && !dmem.DmemWEB;
  assign w_illegal = !dmem.DmemREB && !dmem.DmemWEB;
  assign w_busy    = is_busy(state_q);

`ifdef DMEM_TIMEOUT_EN
  dmem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!w_busy),
    .en_i      (w_busy && !dmem.mem_ack),
    .expired_o (w_timeout)
  );
`else
  // Without the watchdog a request waits for mem_ack indefinitely.
  assign w_timeout = 1'b0;
`endif

  // Next-state, latch and status decode; ack always wins over timeout.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_out_d   = rdata_out_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    w_stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_rd_req) begin
          state_d    = ST_RD;
          mem_addr_d = dmem.req_addr;
          w_stall    = 1'b1;
        end else if (w_wr_req) begin
          state_d     = ST_WR;
          mem_addr_d  = dmem.req_addr;
          mem_wdata_d = dmem.req_wdata;
          w_stall     = 1'b1;
        end else if (w_illegal) begin
          err_d = 1'b1;
        end
      end
      ST_RD: begin
        w_stall = 1'b1;
        if (dmem.mem_ack) begin
          state_d       = ST_DONE;
          rdata_out_d   = dmem.mem_rdata;
          rdata_valid_d = 1'b1;
        end else if (w_timeout) begin
          state_d       = ST_DONE;
          rdata_out_d   = '0;
          rdata_valid_d = 1'b1;
          err_d         = 1'b1;
        end
      end
      ST_WR: begin
        w_stall = 1'b1;
        if (dmem.mem_ack) begin
          state_d = ST_DONE;
        end else if (w_timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        // Strobes here still belong to the instruction that just finished.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_d = is_busy(state_d);
    mem_we_d  = (state_d == ST_WR);
  end

  // State and output registers; async reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_out_q   <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_out_q   <= rdata_out_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  assign dmem.mem_req     = mem_req_q;
  assign dmem.mem_we      = mem_we_q;
  assign dmem.mem_addr    = mem_addr_q;
  assign dmem.mem_wdata   = mem_wdata_q;
  assign dmem.rdata_out   = rdata_out_q;
  assign dmem.rdata_valid = rdata_valid_q;
  assign dmem.err         = err_q;
  assign dmem.stall       = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_ctrl
//  Description : Directed self-checking bench for dmem_access_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  int   stall_cnt;

  dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

  dmem_access_ctrl #(
`ifdef DMEM_TIMEOUT_EN
    .TIMEOUT_CYC (4),
`endif
    .ADDR_W      (32),
    .DATA_W      (32)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .dmem (dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dmem.DmemREB   = 1'b1;
    dmem.DmemWEB   = 1'b1;
    dmem.mem_ack   = 1'b0;
    dmem.mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b1;
    idle_inputs();
    dmem.req_addr  = '0;
    dmem.req_wdata = '0;
    cyc();
    cyc();

    // Reset state
    chk("rst_req",   dmem.mem_req, 0);
    chk("rst_we",    dmem.mem_we, 0);
    chk("rst_addr",  dmem.mem_addr, 0);
    chk("rst_wdata", dmem.mem_wdata, 0);
    chk("rst_rdata", dmem.rdata_out, 0);
    chk("rst_rvld",  dmem.rdata_valid, 0);
    chk("rst_err",   dmem.err, 0);
    chk("rst_stall", dmem.stall, 0);
    rst = 1'b0;
    cyc();

    // 1. Load, ack in first RD cycle
    dmem.DmemREB  = 1'b0;
    dmem.req_addr = 32'h100;
    #1;
    chk("t1_stall_detect", dmem.stall, 1);
    chk("t1_req_detect",   dmem.mem_req, 0);
    cyc();
    dmem.mem_ack   = 1'b1;
    dmem.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_req_rd",   dmem.mem_req, 1);
    chk("t1_we_rd",    dmem.mem_we, 0);
    chk("t1_addr_rd",  dmem.mem_addr, 32'h100);
    chk("t1_stall_rd", dmem.stall, 1);
    cyc();
    dmem.mem_ack = 1'b0;
    #1;
    chk("t1_req_done",   dmem.mem_req, 0);
    chk("t1_stall_done", dmem.stall, 0);
    chk("t1_rvld_done",  dmem.rdata_valid, 1);
    chk("t1_rdata_done", dmem.rdata_out, 32'hDEADBEEF);
    dmem.DmemREB = 1'b1;
    cyc();
    chk("t1_rvld_idle",  dmem.rdata_valid, 0);
    chk("t1_rdata_hold", dmem.rdata_out, 32'hDEADBEEF);
    chk("t1_stall_idle", dmem.stall, 0);

    // 2. Store with 3 wait cycles; address/data inputs change after launch
    dmem.DmemWEB   = 1'b0;
    dmem.req_addr  = 32'h204;
    dmem.req_wdata = 32'h12345678;
    stall_cnt = 0;
    #1;
    if (dmem.stall) stall_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      dmem.req_addr  = 32'hFFFF_0000 + i;
      dmem.req_wdata = 32'hA5A5_0000 + i;
      dmem.mem_ack   = (i == 3);
      #1;
      if (dmem.stall) stall_cnt++;
      chk("t2_req_wr",   dmem.mem_req, 1);
      chk("t2_we_wr",    dmem.mem_we, 1);
      chk("t2_addr_wr",  dmem.mem_addr, 32'h204);
      chk("t2_wdata_wr", dmem.mem_wdata, 32'h12345678);
      chk("t2_rvld_wr",  dmem.rdata_valid, 0);
    end
    cyc();
    dmem.mem_ack = 1'b0;
    #1;
    if (dmem.stall) stall_cnt++;
    chk("t2_stall_total", stall_cnt, 5);
    chk("t2_req_done",    dmem.mem_req, 0);
    chk("t2_rvld_done",   dmem.rdata_valid, 0);
    chk("t2_err_done",    dmem.err, 0);
    dmem.DmemWEB = 1'b1;
    cyc();

    // 3. Illegal strobes
    dmem.DmemREB = 1'b0;
    dmem.DmemWEB = 1'b0;
    #1;
    chk("t3_stall", dmem.stall, 0);
    cyc();
    idle_inputs();
    #1;
    chk("t3_err_pulse", dmem.err, 1);
    chk("t3_req",       dmem.mem_req, 0);
    chk("t3_stall2",    dmem.stall, 0);
    cyc();
    chk("t3_err_clear", dmem.err, 0);
    chk("t3_req2",      dmem.mem_req, 0);

    // 4. Back-to-back loads; stale strobe held through DONE
    dmem.DmemREB  = 1'b0;
    dmem.req_addr = 32'h300;
    #1;
    chk("t4_stall_a", dmem.stall, 1);
    cyc();
    dmem.mem_ack   = 1'b1;
    dmem.mem_rdata = 32'h11111111;
    cyc();
    dmem.mem_ack = 1'b0;
    #1;
    chk("t4_stall_done", dmem.stall, 0);
    chk("t4_rdata_a",    dmem.rdata_out, 32'h11111111);
    chk("t4_rvld_a",     dmem.rdata_valid, 1);
    cyc();
    dmem.req_addr = 32'h304;
    #1;
    chk("t4_req_idle",  dmem.mem_req, 0);
    chk("t4_stall_b",   dmem.stall, 1);
    cyc();
    dmem.mem_ack   = 1'b1;
    dmem.mem_rdata = 32'h22222222;
    #1;
    chk("t4_req_b",  dmem.mem_req, 1);
    chk("t4_addr_b", dmem.mem_addr, 32'h304);
    cyc();
    dmem.mem_ack = 1'b0;
    dmem.DmemREB = 1'b1;
    #1;
    chk("t4_rdata_b", dmem.rdata_out, 32'h22222222);
    chk("t4_rvld_b",  dmem.rdata_valid, 1);
    cyc();
    chk("t4_req_end",   dmem.mem_req, 0);
    chk("t4_stall_end", dmem.stall, 0);

`ifdef DMEM_TIMEOUT_EN
    // 6. Load with no ack, TIMEOUT_CYC=4
    dmem.DmemREB  = 1'b0;
    dmem.req_addr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("t6_req_rd",   dmem.mem_req, 1);
      chk("t6_stall_rd", dmem.stall, 1);
    end
    cyc();
    dmem.DmemREB = 1'b1;
    #1;
    chk("t6_err",       dmem.err, 1);
    chk("t6_rvld",      dmem.rdata_valid, 1);
    chk("t6_rdata",     dmem.rdata_out, 0);
    chk("t6_req_done",  dmem.mem_req, 0);
    chk("t6_stall_done", dmem.stall, 0);
    cyc();
    chk("t6_err_clear", dmem.err, 0);
    chk("t6_req_idle",  dmem.mem_req, 0);
    // Reload rdata_out so the reset check below is meaningful
    dmem.DmemREB  = 1'b0;
    dmem.req_addr = 32'h600;
    cyc();
    dmem.mem_ack   = 1'b1;
    dmem.mem_rdata = 32'h33333333;
    cyc();
    idle_inputs();
    cyc();
`endif

    // 5. Async reset during RD with ack pending
    dmem.DmemREB  = 1'b0;
    dmem.req_addr = 32'h400;
    cyc();
    chk("t5_req_rd", dmem.mem_req, 1);
    #1;
    rst          = 1'b1;
    dmem.DmemREB = 1'b1;
    #1;
    chk("t5_req_async",   dmem.mem_req, 0);
    chk("t5_addr_async",  dmem.mem_addr, 0);
    chk("t5_rdata_async", dmem.rdata_out, 0);
    chk("t5_stall_async", dmem.stall, 0);
    cyc();
    rst = 1'b0;
    dmem.mem_ack   = 1'b1;
    dmem.mem_rdata = 32'h55555555;
    cyc();
    dmem.mem_ack = 1'b0;
    #1;
    chk("t5_rvld_late",  dmem.rdata_valid, 0);
    chk("t5_rdata_late", dmem.rdata_out, 0);
    chk("t5_req_late",   dmem.mem_req, 0);
    chk("t5_err_late",   dmem.err, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
